// File: rtl/serial_shift_capture.sv
// serial_shift_capture: receive-side model of a serial display shift chain.
// Oversamples ser_clk/ser_pen/ser_clr_n/ser_do on SI_ClkIn, deserialises the
// stream like the physical shift-register chain and latches frames on pen rise.
module serial_shift_capture #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic              SI_ClkIn,
    input  logic              SI_Reset,
    input  logic              ser_clk,
    input  logic              ser_pen,
    input  logic              ser_clr_n,
    input  logic              ser_do,
    output logic [WIDTH-1:0]  data_q,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [15:0]       frame_cnt
);

    // Synchroniser bit order: {do, clr_n, pen, clk}; clr_n idles high.
    localparam int unsigned SYNC_W   = 4;
    localparam logic [SYNC_W-1:0] SYNC_RST = 4'b0100;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SYNC_W-1:0] r_s1;
    logic [SYNC_W-1:0] r_s2;
    logic              r_clk_s3;
    logic              r_pen_s3;

    logic [WIDTH-1:0]  r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WIDTH-1:0]  r_data_q;
    logic              r_frame_valid;
    logic              r_frame_err;
    logic [15:0]       r_frame_cnt;

    logic              w_clk_rise;
    logic              w_pen_rise;
    logic              w_clr;
    logic              w_do;
    logic [WIDTH-1:0]  w_sr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_len_ok;

    // Two-flop synchronisers plus history flops for edge detection.
    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            r_s1     <= SYNC_RST;
            r_s2     <= SYNC_RST;
            r_clk_s3 <= 1'b0;
            r_pen_s3 <= 1'b0;
        end else begin
            r_s1     <= {ser_do, ser_clr_n, ser_pen, ser_clk};
            r_s2     <= r_s1;
            r_clk_s3 <= r_s2[0];
            r_pen_s3 <= r_s2[1];
        end
    end

    assign w_clk_rise = r_s2[0] & ~r_clk_s3;
    assign w_pen_rise = r_s2[1] & ~r_pen_s3;
    assign w_clr      = ~r_s2[2];
    assign w_do       = r_s2[3];

    // Next chain contents and bit count: clear wins over a shift.
    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_bit_cnt;
        if (w_clr) begin
            w_sr_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (w_clk_rise) begin
            w_sr_nxt  = {r_sr[WIDTH-2:0], w_do};
            w_cnt_nxt = (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
        end
    end

    assign w_len_ok = (32'(w_cnt_nxt) == 32'(WIDTH));

    // Chain, counters and latched frame; the latch samples the post-clear/shift value.
    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_data_q      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_sr          <= w_sr_nxt;
            r_frame_valid <= w_pen_rise;
            if (w_pen_rise) begin
                r_bit_cnt   <= '0;
                r_data_q    <= w_sr_nxt;
                r_frame_err <= ~w_len_ok;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_bit_cnt   <= w_cnt_nxt;
            end
        end
    end

    assign data_q      = r_data_q;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign bit_cnt     = r_bit_cnt;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_serial_shift_capture.sv
// Bench for serial_shift_capture: one 64-bit and one 16-bit link, directed
// frames plus random frames checked against a bit-queue reference model.
module tb_serial_shift_capture;

    localparam int unsigned W0 = 64;
    localparam int unsigned W1 = 16;
    localparam int unsigned CW = 8;
    localparam int          CNT_SAT = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sclk [2];
    logic        spen [2];
    logic        sclr [2];
    logic        sdo  [2];
    logic [63:0] dq0;
    logic [15:0] dq1;
    logic        fv [2];
    logic        fe [2];
    logic [7:0]  bc [2];
    logic [15:0] fc [2];

    serial_shift_capture #(.WIDTH(W0), .CNT_W(CW)) u_seg (
        .SI_ClkIn(clk), .SI_Reset(rst),
        .ser_clk(sclk[0]), .ser_pen(spen[0]), .ser_clr_n(sclr[0]), .ser_do(sdo[0]),
        .data_q(dq0), .frame_valid(fv[0]), .frame_err(fe[0]),
        .bit_cnt(bc[0]), .frame_cnt(fc[0])
    );

    serial_shift_capture #(.WIDTH(W1), .CNT_W(CW)) u_led (
        .SI_ClkIn(clk), .SI_Reset(rst),
        .ser_clk(sclk[1]), .ser_pen(spen[1]), .ser_clr_n(sclr[1]), .ser_do(sdo[1]),
        .data_q(dq1), .frame_valid(fv[1]), .frame_err(fe[1]),
        .bit_cnt(bc[1]), .frame_cnt(fc[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: bits received since the last clear, count since last latch.
    bit q0[$];
    bit q1[$];
    int mcnt [2];
    int mfc  [2];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int wid(input int l);
        return (l == 0) ? int'(W0) : int'(W1);
    endfunction

    function automatic logic [127:0] dq(input int l);
        return (l == 0) ? 128'(dq0) : 128'(dq1);
    endfunction

    task automatic m_push(input int l, input bit b);
        if (l == 0) begin
            q0.push_back(b);
            if (q0.size() > wid(0)) void'(q0.pop_front());
        end else begin
            q1.push_back(b);
            if (q1.size() > wid(1)) void'(q1.pop_front());
        end
        if (mcnt[l] < CNT_SAT) mcnt[l]++;
    endtask

    task automatic m_clear(input int l);
        if (l == 0) q0.delete(); else q1.delete();
        mcnt[l] = 0;
    endtask

    // Pattern the chain shows: most recent bits, oldest of them most significant.
    function automatic logic [127:0] exp_data(input int l);
        logic [127:0] v;
        int n;
        v = '0;
        n = (l == 0) ? q0.size() : q1.size();
        for (int i = 0; i < n; i++)
            v = v * 2 + 128'((l == 0) ? q0[i] : q1[i]);
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int l, input bit b);
        sdo[l] = b;
        cyc(2);
        sclk[l] = 1'b1;
        m_push(l, b);
        cyc(2);
        sclk[l] = 1'b0;
    endtask

    task automatic send_val(input int l, input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(l, v[i]);
    endtask

    task automatic send_rand(input int l, input int n);
        for (int i = 0; i < n; i++) send_bit(l, 1'($urandom_range(0, 1)));
    endtask

    task automatic clear(input int l, input int n);
        sclr[l] = 1'b0;
        cyc(n);
        sclr[l] = 1'b1;
        m_clear(l);
        cyc(3);
    endtask

    // Pen pulse; with_bit makes the final ser_clk rise coincide with the pen rise.
    task automatic latch(input int l, input string tag, input bit with_bit, input bit b);
        int pulses;
        logic [127:0] ed;
        bit ee;
        pulses = 0;
        if (!with_bit) begin
            cyc(2);
            chk({tag, ".cnt_pre"}, 128'(bc[l]), 128'(mcnt[l]));
        end else begin
            sdo[l] = b;
            cyc(2);
            sclk[l] = 1'b1;
            m_push(l, b);
        end
        spen[l] = 1'b1;
        ed = exp_data(l);
        ee = (mcnt[l] != wid(l));
        mfc[l] = (mfc[l] + 1) & 16'hFFFF;
        mcnt[l] = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fv[l]) pulses++;
            @(posedge clk);
            #1;
            if (i == 1 && with_bit) sclk[l] = 1'b0;
            if (i == 2) spen[l] = 1'b0;
        end
        chk({tag, ".pulses"}, 128'(pulses), 128'(1));
        chk({tag, ".data"}, dq(l), ed);
        chk({tag, ".err"}, 128'(fe[l]), 128'(ee));
        chk({tag, ".fcnt"}, 128'(fc[l]), 128'(mfc[l]));
        chk({tag, ".cnt_post"}, 128'(bc[l]), 128'(0));
    endtask

    task automatic check_zero(input string tag);
        for (int l = 0; l < 2; l++) begin
            chk({tag, ".data"}, dq(l), 128'(0));
            chk({tag, ".fv"}, 128'(fv[l]), 128'(0));
            chk({tag, ".err"}, 128'(fe[l]), 128'(0));
            chk({tag, ".cnt"}, 128'(bc[l]), 128'(0));
            chk({tag, ".fcnt"}, 128'(fc[l]), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] v;
        int l;
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sclk[i] = 1'b0; spen[i] = 1'b0; sclr[i] = 1'b1; sdo[i] = 1'b0;
            mcnt[i] = 0; mfc[i] = 0;
        end
        cyc(3);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);

        // Nominal 64-bit frame.
        send_val(0, 128'h DEADBEEF01234567, 64);
        latch(0, "nominal", 1'b0, 1'b0);
        chk("nominal.const", 128'(dq0), 128'h DEADBEEF01234567);
        chk("nominal.fcnt1", 128'(fc[0]), 128'(1));

        // Short 16-bit frame, then a full one.
        clear(1, 2);
        send_val(1, 128'h3FF, 10);
        latch(1, "short", 1'b0, 1'b0);
        chk("short.const", 128'(dq1), 128'h03FF);
        chk("short.err1", 128'(fe[1]), 128'(1));
        send_val(1, 128'h A5C3, 16);
        latch(1, "full16", 1'b0, 1'b0);
        chk("full16.const", 128'(dq1), 128'h A5C3);
        chk("full16.fcnt2", 128'(fc[1]), 128'(2));

        // Overflow: 20 bits, oldest 4 fall out.
        send_val(1, 128'h F1234, 20);
        latch(1, "overflow", 1'b0, 1'b0);
        chk("overflow.const", 128'(dq1), 128'h1234);
        chk("overflow.err1", 128'(fe[1]), 128'(1));

        // Clear mid-frame, then a full frame; then pen with clear held.
        send_rand(0, 30);
        clear(0, 3);
        send_val(0, 128'h 0123456789ABCDEF, 64);
        latch(0, "clrmid", 1'b0, 1'b0);
        chk("clrmid.const", 128'(dq0), 128'h 0123456789ABCDEF);
        chk("clrmid.err0", 128'(fe[0]), 128'(0));
        sclr[0] = 1'b0;
        m_clear(0);
        cyc(3);
        latch(0, "clrpen", 1'b0, 1'b0);
        sclr[0] = 1'b1;
        cyc(3);
        chk("clrpen.const", 128'(dq0), 128'(0));
        chk("clrpen.err1", 128'(fe[0]), 128'(1));

        // Final ser_clk rise and pen rise on the same edge.
        v = 128'h9C3E;
        send_val(1, v >> 1, 15);
        latch(1, "simul", 1'b1, v[0]);
        chk("simul.const", 128'(dq1), 128'h9C3E);
        chk("simul.err0", 128'(fe[1]), 128'(0));

        // bit_cnt saturation.
        send_rand(1, 260);
        chk("sat.cnt", 128'(bc[1]), 128'(CNT_SAT));
        latch(1, "sat", 1'b0, 1'b0);

        // Reset mid-frame discards partial bits and counters.
        send_rand(0, 40);
        @(posedge clk); #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("rstmid");
        end
        for (int i = 0; i < 2; i++) begin
            m_clear(i);
            mfc[i] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);
        send_rand(0, 64);
        latch(0, "afterrst", 1'b0, 1'b0);
        chk("afterrst.fcnt1", 128'(fc[0]), 128'(1));

        // Random frames around the nominal length on both links.
        for (int k = 0; k < 30; k++) begin
            l = int'($urandom_range(0, 1));
            n = wid(l) + int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 3) == 0) clear(l, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 2) == 0) begin
                send_rand(l, n - 1);
                latch(l, "rand_simul", 1'b1, 1'($urandom_range(0, 1)));
            end else begin
                send_rand(l, n);
                latch(l, "rand", 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
